alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares one 16-bit ALU datapath (operands a, b; 2-bit ctrl; 16-bit out) among NUM_REQ requesters. Round-robin arbitration, valid/ready handshake on each request port, and a single response port tagged with requester ID. Sits between the requesting blocks and the ALU instance in the DUT wrapper. Sequences exactly one operation at a time through the ALU.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ALU_LAT, 1: ALU pipeline latency in cycles, 0 = combinational, range 0..7
- DATA_W, 16: operand/result width
- CTRL_W, 2: ALU op-select width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ x DATA_W  packed operand A per requester
- req_b  in  NUM_REQ x DATA_W  packed operand B per requester
- req_ctrl  in  NUM_REQ x CTRL_W  packed op select per requester
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_ctrl  out  CTRL_W  to ALU ctrl
- alu_out  in  DATA_W  from ALU out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NUM_REQ)  requester index of result
- rsp_data  out  DATA_W  result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, the arbiter grants one index g. req_ready[g]=1 combinationally in the same cycle. On that edge, capture req_a[g], req_b[g], req_ctrl[g], and g into the op registers. Load lat_cnt=ALU_LAT and go to EXEC. If no req_valid, stay in IDLE.
- Round-robin: the pointer starts at 0 after reset. Search runs from the pointer upward with wraparound. After a grant to g, the pointer becomes (g+1) mod NUM_REQ. The pointer changes only on a grant.
- EXEC: alu_a, alu_b, and alu_ctrl are driven from the op registers and held stable. lat_cnt decrements each cycle. In the cycle where lat_cnt==0, register alu_out into rsp_data and go to RESP.
- RESP: rsp_valid=1, with rsp_id and rsp_data stable. On rsp_valid&rsp_ready, go to IDLE. No new grant is issued in RESP.
- req_ready is 0 in EXEC and RESP.
- alu_* outputs keep the last operation's operands while in IDLE.
- Reset, at any time including mid-operation, applies all of the following:
  - state goes to IDLE, pointer goes to 0;
  - op registers, rsp_data, and rsp_id go to 0;
  - rsp_valid, req_ready, and busy go to 0;
  - the in-flight operation is discarded.
- A requester that drops req_valid without a handshake is not an error. The arbiter evaluates only the current cycle's req_valid.

## Timing
- Accept at cycle T (IDLE, handshake).
- EXEC occupies T+1 through T+1+ALU_LAT, with alu_* valid from T+1.
- alu_out is sampled at the end of T+1+ALU_LAT.
- rsp_valid first rises at T+2+ALU_LAT.
- With rsp_ready held high, the next accept is at T+3+ALU_LAT. Peak throughput is one op per ALU_LAT+3 cycles.
- rsp_ready low stalls in RESP indefinitely. Outputs hold.
- ALU_LAT=0: EXEC is one cycle and alu_out is sampled in the same cycle operands are presented.
- All outputs are registered except req_ready, which is combinational from req_valid, state, and pointer.

## Structure
- Shared package alu_share_pkg holds:
  - state enum typedef (IDLE, EXEC, RESP);
  - DATA_W and CTRL_W defaults;
  - the id width function.
- Sub-module rr_arbiter (parameter N) takes req[N], en, and ptr, and returns a one-hot grant[N] and an encoded grant index. It is pure combinational; the pointer register lives in the parent.
- The parent holds the FSM, latency counter, op registers, and response registers.

## Test plan
- Single request (NUM_REQ=4, ALU_LAT=1): requester 2 sends a=16'h0003, b=16'h0004, and the bench ALU model treats ctrl=0 as add. Required: req_ready[2] high at T, alu_a=3 at T+1, rsp_valid at T+3, rsp_id=2, rsp_data=16'h0007, busy high T+1..T+3.
- Fairness: all 4 req_valid held high with rsp_ready=1. Grants go in order 0,1,2,3,0, spaced 4 cycles apart.
- Pointer skip: pointer=1 after granting 0, only req_valid[0] and [3] high. Next grant is 3, then 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid, rsp_id, and rsp_data hold, and no req_ready is asserted. Release gives IDLE on the next cycle.
- Wraparound: a=16'hFFFF, b=16'h0001, add. rsp_data=16'h0000, passed through from the ALU model unmodified.
- Reset mid-EXEC: assert rst for 1 cycle at T+1. Next cycle state is IDLE, rsp_valid=0, alu_a=0, and the pointer is 0. The discarded op never produces a response, and a re-request from requester 0 is granted first.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the ALU sharing arbiter.
// Holds the FSM state encoding, default datapath widths and the requester-id width.
package alu_share_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wraparound.
// Produces a one-hot grant (gated by en) and the encoded winning index.
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0]  upper;
  logic          found_hi;
  logic          found_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Requests at or above the pointer win over the wrapped-around ones.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign upper[gi] = req[gi] && (IW'(gi) >= ptr);
    end
  endgenerate

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) begin
        found_hi = 1'b1;
        idx_hi   = IW'(i);
      end
      if (req[i]) begin
        found_lo = 1'b1;
        idx_lo   = IW'(i);
      end
    end
  end

  assign grant_idx = found_hi ? idx_hi : idx_lo;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = en && found_lo && (grant_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU among NUM_REQ requesters, one operation at a time,
// with round-robin grants and a single ID-tagged response port.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [CTRL_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]           alu_out,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
);

  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT);

  state_t              state_reg;
  state_t              state_next;
  logic [ID_W-1:0]     ptr_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;
  logic [CTRL_W-1:0]   op_ctrl_reg;
  logic [ID_W-1:0]     op_id_reg;
  logic [DATA_W-1:0]   rsp_data_reg;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                arb_en;
  logic                accept;
  logic                capture_rsp;

  logic [DATA_W-1:0]   a_arr    [NUM_REQ];
  logic [DATA_W-1:0]   b_arr    [NUM_REQ];
  logic [CTRL_W-1:0]   ctrl_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]    = req_b[gi*DATA_W +: DATA_W];
      assign ctrl_arr[gi] = req_ctrl[gi*CTRL_W +: CTRL_W];
    end
  endgenerate

  // Grants are suppressed while reset is asserted so req_ready reads zero.
  assign arb_en = (state_reg == IDLE) && !rst;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .en        (arb_en),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = |grant;

  always_comb begin
    state_next  = state_reg;
    capture_rsp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        if (lat_cnt_reg == '0) begin
          state_next  = RESP;
          capture_rsp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      lat_cnt_reg  <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_ctrl_reg  <= '0;
      op_id_reg    <= '0;
      rsp_data_reg <= '0;
    end else begin
      if (accept) begin
        op_a_reg    <= a_arr[grant_idx];
        op_b_reg    <= b_arr[grant_idx];
        op_ctrl_reg <= ctrl_arr[grant_idx];
        op_id_reg   <= grant_idx;
        lat_cnt_reg <= LAT_INIT;
        ptr_reg     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end else if (state_reg == EXEC && lat_cnt_reg != '0) begin
        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
      end
      if (capture_rsp) rsp_data_reg <= alu_out;
    end
  end

  assign req_ready = grant;
  assign alu_a     = op_a_reg;
  assign alu_b     = op_b_reg;
  assign alu_ctrl  = op_ctrl_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = op_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule
